// File: rtl/mrsc_decoder_pipe_if.sv
// Stream bundle for the MRSC decoder: codeword input beat and corrected-data output beat.
// master = upstream producer / downstream consumer side, slave = the decoder.
interface mrsc_decoder_pipe_if #(
  parameter int unsigned LANES = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [32*LANES-1:0]    in_word;
  logic                   out_valid;
  logic                   out_ready;
  logic [16*LANES-1:0]    decoded_word;
  logic [2*LANES-1:0]     error_code;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, decoded_word, error_code
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, decoded_word, error_code
  );
endinterface

// File: rtl/mrsc_decoder_pipe.sv
// Two-stage pipelined multi-lane MRSC decoder (16-bit data / 32-bit codeword).
// Define MRSC_ERR_CNT_EN to build the saturating per-region correction counters.
module mrsc_decoder_pipe #(
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  mrsc_decoder_pipe_if.slave bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   cnt_r1,
  output logic [CNT_W-1:0]   cnt_r2,
  output logic [CNT_W-1:0]   cnt_r3
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CW_W   = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [15:0]       syn;
    logic [2:0]        s12;
    logic [2:0]        s34;
  } stage1_t;

  // Check bits in codeword order {DI1,DI3,DI2,DI4, P1,P3,P2,P4, XA13..XD24}; nibble bit 1 is the MSB.
  function automatic logic [15:0] check_bits(input logic [15:0] d);
    logic [3:0] na, nb, nc, nd, p;
    logic       di1, di2, di3, di4;
    na  = d[15:12];
    nb  = d[11:8];
    nc  = d[7:4];
    nd  = d[3:0];
    di1 = na[3] ^ nb[2] ^ nc[3] ^ nd[2];
    di2 = na[2] ^ nb[3] ^ nc[2] ^ nd[3];
    di3 = na[1] ^ nb[0] ^ nc[1] ^ nd[0];
    di4 = na[0] ^ nb[1] ^ nc[0] ^ nd[1];
    p   = na ^ nb ^ nc ^ nd;
    return {di1, di3, di2, di4,
            p[3], p[1], p[2], p[0],
            na[3] ^ na[1], na[2] ^ na[0],
            nb[3] ^ nb[1], nb[2] ^ nb[0],
            nc[3] ^ nc[1], nc[2] ^ nc[0],
            nd[3] ^ nd[1], nd[2] ^ nd[0]};
  endfunction

  function automatic stage1_t stage1_calc(input logic [CW_W-1:0] w);
    stage1_t s;
    s.data = w[31:16];
    s.syn  = check_bits(w[31:16]) ^ w[15:0];
    s.s12  = 3'(s.syn[15]) + 3'(s.syn[13]) + 3'(s.syn[11]) + 3'(s.syn[9]);
    s.s34  = 3'(s.syn[14]) + 3'(s.syn[12]) + 3'(s.syn[10]) + 3'(s.syn[8]);
    return s;
  endfunction

  // Returns {code, corrected data} for one lane.
  function automatic logic [DATA_W+1:0] stage2_calc(input stage1_t s);
    logic              corr;
    logic [1:0]        code;
    logic [DATA_W-1:0] d;
    logic [3:0]        x13, x24, m;
    for (int v = 0; v < 4; v++) begin
      x13[v] = s.syn[7-2*v];
      x24[v] = s.syn[6-2*v];
    end
    corr = ((|s.syn[15:12]) & (|s.syn[11:8])) | ($countones(s.syn[7:0]) > 1);
    if (!corr)               code = 2'b00;
    else if (s.s12 > s.s34)  code = 2'b01;
    else if (s.s12 < s.s34)  code = 2'b10;
    else                     code = 2'b11;
    d = s.data;
    for (int v = 0; v < 4; v++) begin
      case (code)
        2'b01:   m = {x13[v], x24[v], 2'b00};
        2'b10:   m = {2'b00, x13[v], x24[v]};
        2'b11:   m = {1'b0, x24[v], x13[v], 1'b0};
        default: m = 4'b0000;
      endcase
      d[(15-4*v) -: 4] = d[(15-4*v) -: 4] ^ m;
    end
    return {code, d};
  endfunction

  logic                      en;
  logic                      s1_valid_q;
  stage1_t                   s1_d [LANES];
  stage1_t                   s1_q [LANES];
  logic                      out_valid_q;
  logic [DATA_W*LANES-1:0]   dec_d, dec_q;
  logic [2*LANES-1:0]        code_d, code_q;

  // Single advance enable for the whole pipe; only the output stage can stall it.
  assign en           = !out_valid_q | bus.out_ready;
  assign bus.in_ready = en;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      s1_d[k] = stage1_calc(bus.in_word[CW_W*k +: CW_W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      for (int k = 0; k < LANES; k++) s1_q[k] <= '0;
    end else if (en) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        for (int k = 0; k < LANES; k++) s1_q[k] <= s1_d[k];
      end
    end
  end

  always_comb begin
    dec_d  = '0;
    code_d = '0;
    for (int k = 0; k < LANES; k++) begin
      {code_d[2*k +: 2], dec_d[DATA_W*k +: DATA_W]} = stage2_calc(s1_q[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
      code_q      <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        dec_q  <= dec_d;
        code_q <= code_d;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.decoded_word = dec_q;
  assign bus.error_code   = code_q;

`ifdef MRSC_ERR_CNT_EN
  localparam int unsigned LW    = $clog2(LANES + 1);
  localparam int unsigned SUM_W = CNT_W + LW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [LW-1:0] a);
    logic [SUM_W-1:0] s;
    s = SUM_W'(c) + SUM_W'(a);
    return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(s);
  endfunction

  logic [LW-1:0]    n_r1, n_r2, n_r3;
  logic             handshake;
  logic [CNT_W-1:0] cnt_r1_q, cnt_r2_q, cnt_r3_q;

  assign handshake = out_valid_q & bus.out_ready;

  // Lanes carrying each region code in the beat currently on the output.
  always_comb begin
    n_r1 = '0;
    n_r2 = '0;
    n_r3 = '0;
    for (int k = 0; k < LANES; k++) begin
      n_r1 = n_r1 + LW'(code_q[2*k +: 2] == 2'b01);
      n_r2 = n_r2 + LW'(code_q[2*k +: 2] == 2'b10);
      n_r3 = n_r3 + LW'(code_q[2*k +: 2] == 2'b11);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r1_q <= '0;
      cnt_r2_q <= '0;
      cnt_r3_q <= '0;
    end else if (cnt_clr) begin
      cnt_r1_q <= '0;
      cnt_r2_q <= '0;
      cnt_r3_q <= '0;
    end else if (handshake) begin
      cnt_r1_q <= sat_add(cnt_r1_q, n_r1);
      cnt_r2_q <= sat_add(cnt_r2_q, n_r2);
      cnt_r3_q <= sat_add(cnt_r3_q, n_r3);
    end
  end

  assign cnt_r1 = cnt_r1_q;
  assign cnt_r2 = cnt_r2_q;
  assign cnt_r3 = cnt_r3_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_r1 = '0;
  assign cnt_r2 = '0;
  assign cnt_r3 = '0;
`endif

endmodule

// File: tb/tb_mrsc_decoder_pipe.sv
// Randomized bench for mrsc_decoder_pipe against a nibble-level reference decoder and beat scoreboard.
// Counter expectations follow MRSC_ERR_CNT_EN (zero when it is undefined).
module tb_mrsc_decoder_pipe;
  localparam int unsigned LANES = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned BW    = 18 * LANES;
  localparam int          CMAX  = (1 << CNT_W) - 1;
`ifdef MRSC_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] cnt_r1, cnt_r2, cnt_r3;

  always #5 clk = ~clk;

  mrsc_decoder_pipe_if #(.LANES(LANES)) bus ();

  mrsc_decoder_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .cnt_r1  (cnt_r1),
    .cnt_r2  (cnt_r2),
    .cnt_r3  (cnt_r3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: recompute checks from the nibble bits directly.
  function automatic logic [15:0] chk16(input logic [15:0] d);
    logic n [4][4];
    logic p [4];
    logic [15:0] r;
    logic di1, di2, di3, di4;
    for (int v = 0; v < 4; v++)
      for (int j = 0; j < 4; j++) n[v][j] = d[15-4*v-j];
    di1 = n[0][0] ^ n[1][1] ^ n[2][0] ^ n[3][1];
    di2 = n[0][1] ^ n[1][0] ^ n[2][1] ^ n[3][0];
    di3 = n[0][2] ^ n[1][3] ^ n[2][2] ^ n[3][3];
    di4 = n[0][3] ^ n[1][2] ^ n[2][3] ^ n[3][2];
    for (int j = 0; j < 4; j++) p[j] = n[0][j] ^ n[1][j] ^ n[2][j] ^ n[3][j];
    r[15:8] = {di1, di3, di2, di4, p[0], p[2], p[1], p[3]};
    for (int v = 0; v < 4; v++) begin
      r[7-2*v] = n[v][0] ^ n[v][2];
      r[6-2*v] = n[v][1] ^ n[v][3];
    end
    return r;
  endfunction

  function automatic logic [17:0] model_lane(input logic [31:0] w);
    logic [15:0] syn, d;
    logic [1:0]  code;
    int s12, s34, nx, j13, j24;
    bit corr;
    syn  = chk16(w[31:16]) ^ w[15:0];
    d    = w[31:16];
    s12  = int'(syn[15]) + int'(syn[13]) + int'(syn[11]) + int'(syn[9]);
    s34  = int'(syn[14]) + int'(syn[12]) + int'(syn[10]) + int'(syn[8]);
    nx   = $countones(syn[7:0]);
    corr = ((syn[15:12] != 4'h0) && (syn[11:8] != 4'h0)) || (nx > 1);
    j13 = 0; j24 = 1; code = 2'b00;
    if (corr) begin
      if (s12 > s34)      begin code = 2'b01; j13 = 0; j24 = 1; end
      else if (s12 < s34) begin code = 2'b10; j13 = 2; j24 = 3; end
      else                begin code = 2'b11; j13 = 2; j24 = 1; end
      for (int v = 0; v < 4; v++) begin
        d[15-4*v-j13] = d[15-4*v-j13] ^ syn[7-2*v];
        d[15-4*v-j24] = d[15-4*v-j24] ^ syn[6-2*v];
      end
    end
    return {code, d};
  endfunction

  function automatic logic [BW-1:0] model_beat(input logic [32*LANES-1:0] w);
    logic [16*LANES-1:0] dw;
    logic [2*LANES-1:0]  ec;
    logic [17:0]         l;
    for (int k = 0; k < LANES; k++) begin
      l = model_lane(w[32*k +: 32]);
      dw[16*k +: 16] = l[15:0];
      ec[2*k +: 2]   = l[17:16];
    end
    return {ec, dw};
  endfunction

  function automatic logic [31:0] rand_cw();
    logic [15:0] d;
    logic [31:0] w;
    d = 16'($urandom);
    w = {d, chk16(d)};
    if ($urandom_range(0, 3) == 0) return $urandom;
    for (int i = $urandom_range(0, 3); i > 0; i--) w[$urandom_range(0, 31)] ^= 1'b1;
    return w;
  endfunction

  function automatic logic [32*LANES-1:0] rand_beat();
    logic [32*LANES-1:0] w;
    for (int k = 0; k < LANES; k++) w[32*k +: 32] = rand_cw();
    return w;
  endfunction

  logic [BW-1:0]       exp_q [$];
  int                  m_cnt [3] = '{0, 0, 0};
  logic                s_ov, s_ir, acc;
  logic [16*LANES-1:0] s_dw;
  logic [2*LANES-1:0]  s_ec;

  function automatic logic [CNT_W-1:0] exp_cnt(input int r);
    return CNT_ON ? CNT_W'(m_cnt[r]) : '0;
  endfunction

  task automatic check_cnts(input string tag);
    check_eq({tag, "_r1"}, 64'(cnt_r1), 64'(exp_cnt(0)));
    check_eq({tag, "_r2"}, 64'(cnt_r2), 64'(exp_cnt(1)));
    check_eq({tag, "_r3"}, 64'(cnt_r3), 64'(exp_cnt(2)));
  endtask

  // One clock cycle: drive at negedge, settle, score handshakes.
  task automatic step(input logic iv, input logic [32*LANES-1:0] w, input logic ordy,
                      input logic clr, output logic accepted);
    logic [BW-1:0] head;
    @(negedge clk);
    check_cnts("cnt");
    bus.in_valid  = iv;
    bus.in_word   = w;
    bus.out_ready = ordy;
    cnt_clr       = clr;
    #1;
    s_ov = bus.out_valid;
    s_ir = bus.in_ready;
    s_dw = bus.decoded_word;
    s_ec = bus.error_code;
    check_eq("in_ready", 64'(s_ir), 64'(!s_ov || ordy));
    if (s_ov) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 64'(s_ov), 64'(0));
      end else begin
        head = exp_q[0];
        check_eq("out_beat", 64'({s_ec, s_dw}), 64'(head));
        if (ordy) begin
          void'(exp_q.pop_front());
          if (!clr) begin
            for (int k = 0; k < LANES; k++) begin
              int c;
              c = int'(head[16*LANES + 2*k +: 2]);
              if (c != 0) m_cnt[c-1] = (m_cnt[c-1] + 1 > CMAX) ? CMAX : m_cnt[c-1] + 1;
            end
          end
        end
      end
    end
    if (clr) m_cnt = '{0, 0, 0};
    accepted = iv & s_ir;
    if (accepted) exp_q.push_back(model_beat(w));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
    check_eq("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
    exp_q.delete();
    m_cnt = '{0, 0, 0};
    check_cnts("rst_cnt");
    @(posedge clk);
    #1;
    check_eq("rst_hold_valid", 64'(bus.out_valid), 64'(0));
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32*LANES-1:0] words [8];
    int idx, c;
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b1;
    #2;
    check_eq("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check_eq("reset_in_ready", 64'(bus.in_ready), 64'(1));
    check_eq("reset_decoded", 64'(bus.decoded_word), 64'(0));
    check_eq("reset_code", 64'(bus.error_code), 64'(0));
    check_cnts("reset_cnt");
    @(negedge clk);
    rst = 1'b0;

    // All-zero codewords decode clean after two cycles
    step(1'b1, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    check_eq("zero_lat1", 64'(s_ov), 64'(0));
    step(1'b0, '0, 1'b1, 1'b0, acc);
    check_eq("zero_valid", 64'(s_ov), 64'(1));
    check_eq("zero_data", 64'(s_dw), 64'(0));
    check_eq("zero_code", 64'(s_ec), 64'(0));

    // A1 flip on lane 0 (region 1), A4 flip on lane 1 (region 2)
    step(1'b1, {32'h1000_0000, 32'h8000_0000}, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    check_eq("a1a4_valid", 64'(s_ov), 64'(1));
    check_eq("a1a4_data", 64'(s_dw), 64'(0));
    check_eq("a1a4_code", 64'(s_ec), 64'(4'b1001));
    step(1'b0, '0, 1'b1, 1'b0, acc);
    check_eq("a1a4_cnt_r1", 64'(cnt_r1), 64'(CNT_ON ? 1 : 0));
    check_eq("a1a4_cnt_r2", 64'(cnt_r2), 64'(CNT_ON ? 1 : 0));

    // A2+A3 flip on lane 0 -> region 3
    step(1'b1, {32'h0000_0000, 32'h6000_0000}, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    check_eq("a23_data", 64'(s_dw), 64'(0));
    check_eq("a23_code", 64'(s_ec), 64'(4'b0011));
    step(1'b0, '0, 1'b1, 1'b0, acc);
    check_eq("a23_cnt_r3", 64'(cnt_r3), 64'(CNT_ON ? 1 : 0));

    // Eight back-to-back beats with a three-cycle output stall
    for (int i = 0; i < 8; i++) words[i] = rand_beat();
    idx = 0;
    c = 0;
    while (idx < 8 && c < 40) begin
      logic ordy;
      ordy = !(c >= 3 && c < 6);
      step(1'b1, words[idx], ordy, 1'b0, acc);
      if (!ordy && s_ov) check_eq("stall_in_ready", 64'(s_ir), 64'(0));
      if (acc) idx++;
      c++;
    end
    check_eq("stall_all_sent", 64'(idx), 64'(8));
    drain();

    // Region-1 saturation, then clear racing a region-1 handshake
    step(1'b0, '0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 5; i++) step(1'b1, {32'h0, 32'h8000_0000}, 1'b1, 1'b0, acc);
    drain();
    check_eq("sat_cnt_r1", 64'(cnt_r1), 64'(CNT_ON ? 3 : 0));
    step(1'b1, {32'h0, 32'h8000_0000}, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b1, acc);
    check_eq("clr_hs_valid", 64'(s_ov), 64'(1));
    step(1'b0, '0, 1'b1, 1'b0, acc);
    check_eq("clr_cnt_r1", 64'(cnt_r1), 64'(0));

    // Reset with two beats in flight; neither may appear afterwards
    step(1'b1, {32'h0, 32'h8000_0000}, 1'b1, 1'b0, acc);
    step(1'b1, {32'h1000_0000, 32'h0}, 1'b1, 1'b0, acc);
    do_reset();
    idle(5);
    step(1'b1, {32'h8000_0000, 32'h6000_0000}, 1'b1, 1'b0, acc);
    drain();

    // Random traffic, back-pressure and clears
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step(1'($urandom_range(0, 9) < 7), rand_beat(), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 39) == 0), acc);
    end
    drain();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
